// File: rtl/pwm_led_pkg.sv
// Shared register map, CTRL field positions and channel types for the PWM LED peripheral.
package pwm_led_pkg;

    localparam int NUM_CH = 4;
    localparam int DUTY_W = 8;

    localparam logic [4:0] OFF_DUTY_LED = 5'h00;
    localparam logic [4:0] OFF_DUTY_R   = 5'h04;
    localparam logic [4:0] OFF_DUTY_G   = 5'h08;
    localparam logic [4:0] OFF_DUTY_B   = 5'h0C;
    localparam logic [4:0] OFF_CTRL     = 5'h10;
    localparam logic [4:0] OFF_STATUS   = 5'h14;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_BREATHE_BIT = 1;
    localparam int CTRL_PRESC_LSB   = 8;

    // Channel order: 0 = led, 1 = red, 2 = green, 3 = blue.
    typedef logic [NUM_CH-1:0][DUTY_W-1:0] duty_array_t;

    typedef enum logic [1:0] {
        ACC_BYTE = 2'd0,
        ACC_HALF = 2'd1,
        ACC_WORD = 2'd2,
        ACC_BAD  = 2'd3
    } access_size_t;

    function automatic access_size_t decode_size(input logic [2:0] f3);
        access_size_t size;
        case (f3[1:0])
            2'b00:   size = ACC_BYTE;
            2'b01:   size = ACC_HALF;
            2'b10:   size = ACC_WORD;
            default: size = ACC_BAD;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: glitch-free shadow duty, compare against the shared counter, registered output.
module pwm_channel
    import pwm_led_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic [W-1:0] pwm_cnt,
    output logic         pwm_out
);

    logic [W-1:0] shadow_reg, shadow_next;
    logic         out_reg, out_next;

    // While disabled the shadow follows the live duty so enabling starts with it at once.
    always_comb begin
        shadow_next = shadow_reg;
        if (!en || load) begin
            shadow_next = load_value;
        end
        out_next = en && (pwm_cnt < shadow_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_reg <= '0;
            out_reg    <= 1'b0;
        end else begin
            shadow_reg <= shadow_next;
            out_reg    <= out_next;
        end
    end

    assign pwm_out = out_reg;

endmodule

// File: rtl/pwm_led_periph.sv
// Memory-mapped four-channel PWM LED peripheral on the core's dmem port.
// Define PWM_LED_BREATHE_EN to add the CTRL.BREATHE triangle-ramp dimming mode.
module pwm_led_periph
    import pwm_led_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'hFFFF_FFC0,
    parameter int          PWM_BITS      = 8,
    parameter int          PRESCALE_BITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    input  logic [2:0]  funct3,
    output logic [31:0] dmem_data_out,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    logic                     in_window;
    logic                     wr_ok;
    logic [4:0]               reg_offset;

    duty_array_t              duty_reg, duty_next;
    logic                     en_reg, en_next;
    logic [PRESCALE_BITS-1:0] prescale_reg, prescale_next;
    logic [PRESCALE_BITS-1:0] presc_cnt_reg, presc_cnt_next;
    logic [PWM_BITS-1:0]      pwm_cnt_reg, pwm_cnt_next;
    logic                     tick;
    logic                     wrap;
    logic [31:0]              rdata_reg, rdata_next;
    logic [NUM_CH-1:0]        ch_out;

    // Access size is decoded for completeness; every size writes the same register fields.
    access_size_t             unused_access_size;
    logic                     unused_bits;

    assign unused_access_size = decode_size(funct3);
    assign unused_bits        = ^{dmem_data_in[31:16], unused_access_size};

    assign in_window  = (dmem_address[31:5] == BASE_ADDR[31:5]);
    assign wr_ok      = dmem_wren && in_window && (dmem_address[1:0] == 2'b00);
    assign reg_offset = {dmem_address[4:2], 2'b00};

`ifdef PWM_LED_BREATHE_EN
    logic                breathe_reg, breathe_next;
    logic                breathe_active;
    logic [PWM_BITS-1:0] ramp_reg, ramp_next;
    logic                ramp_down_reg, ramp_down_next;

    assign breathe_active = en_reg && breathe_reg;
`endif

    // Register writes
    always_comb begin
        duty_next     = duty_reg;
        en_next       = en_reg;
        prescale_next = prescale_reg;
`ifdef PWM_LED_BREATHE_EN
        breathe_next  = breathe_reg;
`endif
        if (wr_ok) begin
            case (reg_offset)
                OFF_DUTY_LED: duty_next[0] = dmem_data_in[DUTY_W-1:0];
                OFF_DUTY_R:   duty_next[1] = dmem_data_in[DUTY_W-1:0];
                OFF_DUTY_G:   duty_next[2] = dmem_data_in[DUTY_W-1:0];
                OFF_DUTY_B:   duty_next[3] = dmem_data_in[DUTY_W-1:0];
                OFF_CTRL: begin
                    en_next       = dmem_data_in[CTRL_EN_BIT];
                    prescale_next = dmem_data_in[CTRL_PRESC_LSB +: PRESCALE_BITS];
`ifdef PWM_LED_BREATHE_EN
                    breathe_next  = dmem_data_in[CTRL_BREATHE_BIT];
`endif
                end
                default: ;
            endcase
        end
    end

    // Prescaler and PWM counter; tick uses the PRESCALE in force this cycle.
    assign tick = en_reg && (presc_cnt_reg == prescale_reg);
    assign wrap = tick && (pwm_cnt_reg == {PWM_BITS{1'b1}});

    always_comb begin
        presc_cnt_next = presc_cnt_reg;
        pwm_cnt_next   = pwm_cnt_reg;
        if (!en_reg) begin
            presc_cnt_next = '0;
            pwm_cnt_next   = '0;
        end else if (tick) begin
            presc_cnt_next = '0;
            pwm_cnt_next   = pwm_cnt_reg + PWM_BITS'(1);
        end else begin
            presc_cnt_next = presc_cnt_reg + PRESCALE_BITS'(1);
        end
    end

`ifdef PWM_LED_BREATHE_EN
    // Triangle ramp stepping once per period: 0..255..0, turning at the ends.
    always_comb begin
        ramp_next      = ramp_reg;
        ramp_down_next = ramp_down_reg;
        if (!en_reg) begin
            ramp_next      = '0;
            ramp_down_next = 1'b0;
        end else if (breathe_active && wrap) begin
            if (!ramp_down_reg) begin
                if (ramp_reg == {PWM_BITS{1'b1}}) begin
                    ramp_next      = ramp_reg - PWM_BITS'(1);
                    ramp_down_next = 1'b1;
                end else begin
                    ramp_next = ramp_reg + PWM_BITS'(1);
                end
            end else begin
                if (ramp_reg == '0) begin
                    ramp_next      = PWM_BITS'(1);
                    ramp_down_next = 1'b0;
                end else begin
                    ramp_next = ramp_reg - PWM_BITS'(1);
                end
            end
        end
    end
`endif

    // Registered read data
    always_comb begin
        rdata_next = '0;
        if (in_window) begin
            case (reg_offset)
                OFF_DUTY_LED: rdata_next[DUTY_W-1:0] = duty_reg[0];
                OFF_DUTY_R:   rdata_next[DUTY_W-1:0] = duty_reg[1];
                OFF_DUTY_G:   rdata_next[DUTY_W-1:0] = duty_reg[2];
                OFF_DUTY_B:   rdata_next[DUTY_W-1:0] = duty_reg[3];
                OFF_CTRL: begin
                    rdata_next[CTRL_EN_BIT]                    = en_reg;
                    rdata_next[CTRL_PRESC_LSB +: PRESCALE_BITS] = prescale_reg;
`ifdef PWM_LED_BREATHE_EN
                    rdata_next[CTRL_BREATHE_BIT]               = breathe_reg;
`endif
                end
                OFF_STATUS:   rdata_next[PWM_BITS-1:0] = pwm_cnt_reg;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            duty_reg      <= '0;
            en_reg        <= 1'b0;
            prescale_reg  <= '0;
            presc_cnt_reg <= '0;
            pwm_cnt_reg   <= '0;
            rdata_reg     <= '0;
`ifdef PWM_LED_BREATHE_EN
            breathe_reg   <= 1'b0;
            ramp_reg      <= '0;
            ramp_down_reg <= 1'b0;
`endif
        end else begin
            duty_reg      <= duty_next;
            en_reg        <= en_next;
            prescale_reg  <= prescale_next;
            presc_cnt_reg <= presc_cnt_next;
            pwm_cnt_reg   <= pwm_cnt_next;
            rdata_reg     <= rdata_next;
`ifdef PWM_LED_BREATHE_EN
            breathe_reg   <= breathe_next;
            ramp_reg      <= ramp_next;
            ramp_down_reg <= ramp_down_next;
`endif
        end
    end

    // Channels; the shadow load at wrap sees the pre-write duty, so a same-cycle write lands next period.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [PWM_BITS-1:0] load_value;
`ifdef PWM_LED_BREATHE_EN
            logic [2*PWM_BITS-1:0] scaled;
            assign scaled     = {{PWM_BITS{1'b0}}, duty_reg[gi]} * {{PWM_BITS{1'b0}}, ramp_reg};
            assign load_value = breathe_active ? scaled[2*PWM_BITS-1:PWM_BITS] : duty_reg[gi];
`else
            assign load_value = duty_reg[gi];
`endif
            pwm_channel #(
                .W(PWM_BITS)
            ) u_channel (
                .clk       (clk),
                .reset     (reset),
                .en        (en_reg),
                .load      (wrap),
                .load_value(load_value),
                .pwm_cnt   (pwm_cnt_reg),
                .pwm_out   (ch_out[gi])
            );
        end
    endgenerate

    assign dmem_data_out = rdata_reg;
    assign led           = ch_out[0];
    assign red           = ch_out[1];
    assign green         = ch_out[2];
    assign blue          = ch_out[3];

endmodule

// File: tb/tb_pwm_led_periph.sv
// Directed bench for pwm_led_periph: register access, duty counts, prescale timing and reset.
module tb_pwm_led_periph;

    localparam logic [31:0] BASE = 32'hFFFF_FFC0;

    logic        clk;
    logic        reset;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [2:0]  funct3;
    logic [31:0] dmem_data_out;
    logic        led, red, green, blue;

    int vectors;
    int miscompares;

    pwm_led_periph dut (
        .clk          (clk),
        .reset        (reset),
        .dmem_wren    (dmem_wren),
        .dmem_address (dmem_address),
        .dmem_data_in (dmem_data_in),
        .funct3       (funct3),
        .dmem_data_out(dmem_data_out),
        .led          (led),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        @(negedge clk);
        dmem_wren    = 1'b1;
        dmem_address = addr;
        dmem_data_in = data;
        funct3       = f3;
        @(negedge clk);
        dmem_wren    = 1'b0;
        funct3       = 3'b010;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        dmem_address = addr;
        @(negedge clk);
        data = dmem_data_out;
    endtask

    logic [31:0] rd;
    int          cnt_a, cnt_b, cnt_c, cnt_d;

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset        = 1'b1;
        dmem_wren    = 1'b0;
        dmem_address = BASE;
        dmem_data_in = '0;
        funct3       = 3'b010;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_led", {31'b0, led}, 32'd0);
        check("rst_red", {31'b0, red}, 32'd0);
        check("rst_green", {31'b0, green}, 32'd0);
        check("rst_blue", {31'b0, blue}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            bus_read(BASE + 32'(i * 4), rd);
            check($sformatf("rst_read_%02h", i * 4), rd, 32'd0);
        end

        // DUTY_R=64 with EN, PRESCALE=0: 64 of 256 cycles high
        bus_write(BASE + 32'h04, 32'd64, 3'b010);
        bus_write(BASE + 32'h10, 32'h0000_0001, 3'b010);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            cnt_a += int'(led);
            cnt_b += int'(red);
            cnt_c += int'(green);
            cnt_d += int'(blue);
        end
        check("red_high_cnt", 32'(cnt_b), 32'd64);
        check("led_high_cnt", 32'(cnt_a), 32'd0);
        check("green_high_cnt", 32'(cnt_c), 32'd0);
        check("blue_high_cnt", 32'(cnt_d), 32'd0);

        // DUTY_LED=128, then change to 16 mid-period at pwm_cnt=100
        bus_write(BASE + 32'h10, 32'h0000_0000, 3'b010);
        bus_write(BASE + 32'h00, 32'd128, 3'b010);
        bus_write(BASE + 32'h10, 32'h0000_0001, 3'b010);
        cnt_a = 0; cnt_b = 0;
        for (int i = 1; i <= 512; i++) begin
            @(negedge clk);
            if (i <= 256) cnt_a += int'(led);
            else          cnt_b += int'(led);
            if (i == 100) begin
                dmem_wren    = 1'b1;
                dmem_address = BASE + 32'h00;
                dmem_data_in = 32'd16;
            end else if (i == 101) begin
                dmem_wren = 1'b0;
            end
        end
        check("led_period_old", 32'(cnt_a), 32'd128);
        check("led_period_new", 32'(cnt_b), 32'd16);
        bus_read(BASE + 32'h00, rd);
        check("duty_led_read", rd, 32'd16);

        // PRESCALE=3: STATUS steps every 4 cycles, period 1024
        bus_write(BASE + 32'h10, 32'h0000_0000, 3'b010);
        bus_write(BASE + 32'h10, 32'h0000_0301, 3'b010);
        dmem_address = BASE + 32'h14;
        cnt_a = 0; cnt_b = 0;
        for (int j = 1; j <= 1024; j++) begin
            @(negedge clk);
            cnt_a += int'(led);
            cnt_b += int'(red);
            if (j == 1 || j == 4 || j == 5 || j == 9 || j == 401 || j == 1024)
                check($sformatf("status_j%0d", j), dmem_data_out, 32'((j - 1) / 4));
        end
        check("led_cnt_presc", 32'(cnt_a), 32'd64);
        check("red_cnt_presc", 32'(cnt_b), 32'd256);

        // Ignored writes and reserved/outside reads
        bus_write(BASE + 32'h02, 32'h0000_00FF, 3'b010);
        bus_write(BASE + 32'h20, 32'h0000_00AA, 3'b010);
        bus_write(BASE + 32'h14, 32'h0000_0055, 3'b010);
        bus_read(BASE + 32'h00, rd);
        check("duty_led_kept", rd, 32'd16);
        bus_read(BASE + 32'h20, rd);
        check("outside_read", rd, 32'd0);
        bus_read(BASE + 32'h18, rd);
        check("reserved_read", rd, 32'd0);
        bus_read(BASE + 32'h10, rd);
        check("ctrl_read", rd, 32'h0000_0301);
        bus_write(BASE + 32'h08, 32'h1234_5699, 3'b000);
        bus_read(BASE + 32'h08, rd);
        check("sb_duty_g", rd, 32'h0000_0099);
        bus_read(BASE + 32'h04, rd);
        check("duty_r_read", rd, 32'd64);

        // Reset mid-period with DUTY_B=200
        bus_write(BASE + 32'h10, 32'h0000_0000, 3'b010);
        bus_write(BASE + 32'h0C, 32'd200, 3'b010);
        bus_write(BASE + 32'h10, 32'h0000_0001, 3'b010);
        repeat (50) @(negedge clk);
        check("blue_pre_reset", {31'b0, blue}, 32'd1);
        reset        = 1'b1;
        dmem_address = BASE + 32'h0C;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_led", {31'b0, led}, 32'd0);
        check("post_rst_red", {31'b0, red}, 32'd0);
        check("post_rst_green", {31'b0, green}, 32'd0);
        check("post_rst_blue", {31'b0, blue}, 32'd0);
        check("post_rst_rdata", dmem_data_out, 32'd0);
        @(negedge clk);
        check("post_rst_duty_b", dmem_data_out, 32'd0);
        repeat (10) @(negedge clk);
        check("post_rst_blue_idle", {31'b0, blue}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
